demux_1x4_n_reg: RTL and testbench
==================================

Name: demux_1x4_n_reg

Overview:
- Registered 1-to-4 demultiplexer for BITS-wide words. It is the distributing counterpart of the 4x1 mux: one input word is steered into one of four holding registers.
- Each holding register has a ready flag and a read-acknowledge handshake. A dropped-write error pulse and a saturating drop counter are provided.
- Destination comes from SEL (manual mode) or from an internal round-robin pointer (auto mode).
- Sits between a single data producer and four consumers in the lab datapath.

Parameters:
BITS, 4, width of data input and of each output register

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
D  input  BITS  data word to distribute
SEL  input  2  destination channel in manual mode
escreve  input  1  write strobe, sampled on rising edge
auto  input  1  1 = destination from internal pointer; 0 = from SEL
lido  input  4  per-channel read acknowledge (bit i for channel i)
Q0, Q1, Q2, Q3  output  BITS each  channel holding registers
pronto  output  4  per-channel ready flag (bit i = Qi holds unread data)
cheio  output  1  1 when all four pronto bits are 1 (combinational from registers)
erro  output  1  one-cycle pulse: write dropped
descartes  output  4  saturating count of dropped writes
ponteiro  output  2  current round-robin pointer

Behaviour:
- One clock; reset is asynchronous and active-high, named reset; clock is named clock.
- Reset (asserted at any time, including mid-operation): Q0..Q3 = 0, pronto = 0000, erro = 0, descartes = 0, ponteiro = 00, cheio = 0.
  - Effect is immediate, not waiting for a clock edge.
  - First edge after deassertion behaves normally.
- Target channel t = auto ? ponteiro : SEL, evaluated at the rising edge.
- Write accepted when escreve=1 and (pronto[t]=0 or lido[t]=1):
  - Qt <= D; pronto[t] <= 1.
  - If auto=1: ponteiro <= ponteiro+1, wrapping 3 -> 0.
  - Qt and pronto[t] are visible one cycle after the accepting edge.
- Write dropped when escreve=1, pronto[t]=1 and lido[t]=0:
  - Qt unchanged; erro <= 1 for exactly one cycle.
  - descartes <= descartes+1, saturating at 15 (stays 15, no wrap).
  - ponteiro not advanced.
- erro <= 0 on every edge without a dropped write.
- Acknowledge: lido[i]=1 with pronto[i]=1 clears pronto[i] at the edge. Qi keeps its value.
  - lido[i]=1 with pronto[i]=0 is ignored.
  - Multiple lido bits in one cycle are processed independently.
- Simultaneous write to t and lido[t]=1: write wins. Qt <= D, pronto[t] stays 1, no error.
- Simultaneous write to t and lido[j], j != t: both take effect.
- Manual mode (auto=0): ponteiro holds its value. Switching auto on resumes from the held pointer.
- escreve=0: no data, pointer or counter change; only acknowledges act.
- cheio = pronto[0] & pronto[1] & pronto[2] & pronto[3]. No other combinational paths from inputs to outputs.

Optional Feature:
- Macro DEMUX_ZERO_EMPTY_EN.
- When defined: each Qi output is driven as all-zero whenever pronto[i]=0, so cleared channels read 0. Internal registers still retain their data.
- When undefined: Qi always shows its holding register, including after acknowledge.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then manual writes (auto=0): D=3,SEL=3; D=2,SEL=2; D=1,SEL=1; D=0,SEL=0.
  -> Q3..Q0 = 3,2,1,0; pronto = 1111; cheio = 1; erro never 1.
- Auto mode from reset: six writes with D = A,B,C,D,E,F and no acks.
  -> Q0..Q3 = A,B,C,D; ponteiro = 00 after the fourth write.
  -> Writes 5 and 6 dropped: erro pulses twice, descartes = 2, ponteiro stays 00.
- Channel 1 full; same edge escreve=1, SEL=1, D=5, lido=0010.
  -> Q1 = 5, pronto[1] = 1, erro = 0, descartes unchanged.
- Channel 2 full, lido=0100 alone.
  -> pronto[2] = 0 next cycle; Q2 retains value without the macro, reads 0 with DEMUX_ZERO_EMPTY_EN.
- Twenty writes to full channel 0 with no acks.
  -> descartes saturates at 15 and stays 15; erro pulses on every dropped write.
- Assert reset asynchronously mid-sequence with pronto = 1011 and descartes = 7.
  -> All outputs 0 before the next clock edge; first write after release goes to channel 0 in auto mode.

Source files
------------

// File: rtl/demux_1x4_n_reg.sv
// Registered 1-to-4 demultiplexer with per-channel ready/acknowledge handshake,
// dropped-write error pulse and saturating drop counter.
// Optional build macro DEMUX_ZERO_EMPTY_EN: channels without unread data read as zero.
module demux_1x4_n_reg #(
   parameter int BITS = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [BITS-1:0] D,
   input  logic [1:0]      SEL,
   input  logic            escreve,
   input  logic            auto,
   input  logic [3:0]      lido,
   output logic [BITS-1:0] Q0,
   output logic [BITS-1:0] Q1,
   output logic [BITS-1:0] Q2,
   output logic [BITS-1:0] Q3,
   output logic [3:0]      pronto,
   output logic            cheio,
   output logic            erro,
   output logic [3:0]      descartes,
   output logic [1:0]      ponteiro
);

   localparam logic [3:0] DROP_MAX = 4'hF;

   logic [BITS-1:0] hold [4];
   logic [1:0]      target;
   logic            accept;
   logic            drop;
   logic [3:0]      pronto_nxt;

   // A full channel may still be overwritten on the same edge its consumer acknowledges it.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      target     = auto ? ponteiro : SEL;
      accept     = 1'b0;
      drop       = 1'b0;
      pronto_nxt = pronto & ~lido;
      if (escreve) begin
         if (!pronto[target] || lido[target]) begin
            accept             = 1'b1;
            pronto_nxt[target] = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the holding registers are reset too, because Q0..Q3 must read zero out of reset.
         for (int i = 0; i < 4; i++) hold[i] <= '0;
         pronto    <= '0;
         erro      <= 1'b0;
         descartes <= '0;
         ponteiro  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         pronto <= pronto_nxt;
         erro   <= drop;
         if (accept) begin
            hold[target] <= D;
            if (auto) ponteiro <= ponteiro + 2'd1;
         end
         if (drop && descartes != DROP_MAX) descartes <= descartes + 4'd1;
      end
   end

   assign cheio = &pronto;

`ifdef DEMUX_ZERO_EMPTY_EN
   assign Q0 = pronto[0] ? hold[0] : '0;
   assign Q1 = pronto[1] ? hold[1] : '0;
   assign Q2 = pronto[2] ? hold[2] : '0;
   assign Q3 = pronto[3] ? hold[3] : '0;
`else
   assign Q0 = hold[0];
   assign Q1 = hold[1];
   assign Q2 = hold[2];
   assign Q3 = hold[3];
`endif

endmodule

// File: tb/tb_demux_1x4_n_reg.sv
// Self-checking bench for demux_1x4_n_reg: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural channel model.
module tb_demux_1x4_n_reg;

   localparam int BITS = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [BITS-1:0] D = '0;
   logic [1:0]      SEL = '0;
   logic            escreve = 1'b0;
   logic            auto = 1'b0;
   logic [3:0]      lido = '0;
   logic [BITS-1:0] Q0, Q1, Q2, Q3;
   logic [3:0]      pronto;
   logic            cheio;
   logic            erro;
   logic [3:0]      descartes;
   logic [1:0]      ponteiro;

   int tests  = 0;
   int failed = 0;

   demux_1x4_n_reg #(.BITS(BITS)) dut (
      .clock(clock), .reset(reset), .D(D), .SEL(SEL), .escreve(escreve),
      .auto(auto), .lido(lido), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3),
      .pronto(pronto), .cheio(cheio), .erro(erro), .descartes(descartes),
      .ponteiro(ponteiro)
   );

   always #5 clock = ~clock;

   // exp_hold packs the stored words as {ch3, ch2, ch1, ch0}
   typedef struct {
      logic [3:0]  d;
      logic [1:0]  sel;
      logic        wr;
      logic        au;
      logic [3:0]  ld;
      logic [15:0] exp_hold;
      logic [3:0]  exp_pronto;
      logic        exp_erro;
      logic [3:0]  exp_desc;
      logic [1:0]  exp_ptr;
   } vec_t;

   vec_t vecs [10];

   // behavioural model state
   int m_q [4];
   bit m_rdy [4];
   int m_cnt;
   int m_ptr;
   bit m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // What the outputs should show for a given stored word set and ready mask.
   function automatic logic [15:0] view(input logic [15:0] h, input logic [3:0] rdy);
      logic [15:0] v;
      v = h;
`ifdef DEMUX_ZERO_EMPTY_EN
      for (int i = 0; i < 4; i++) if (!rdy[i]) v[i*4 +: 4] = 4'h0;
`endif
      return v;
   endfunction

   task automatic check_outs(input string tag, input logic [15:0] h, input logic [3:0] rdy,
                             input logic er, input logic [3:0] dc, input logic [1:0] pt);
      check({tag, ".Q"}, {Q3, Q2, Q1, Q0}, view(h, rdy));
      check({tag, ".pronto"}, pronto, rdy);
      check({tag, ".cheio"}, cheio, (rdy == 4'hF));
      check({tag, ".erro"}, erro, er);
      check({tag, ".descartes"}, descartes, dc);
      check({tag, ".ponteiro"}, ponteiro, pt);
   endtask

   task automatic apply(input logic [3:0] d, input logic [1:0] sel, input logic wr,
                        input logic au, input logic [3:0] ld);
      D = d; SEL = sel; escreve = wr; auto = au; lido = ld;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      D = '0; SEL = '0; escreve = 1'b0; auto = 1'b0; lido = '0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      m_cnt = 0; m_ptr = 0; m_err = 0;
      for (int i = 0; i < 4; i++) begin m_q[i] = 0; m_rdy[i] = 0; end
   endtask

   // Model: acknowledges clear first, then an accepted write sets its channel (write wins).
   task automatic model_step(input int d, input int sel, input bit wr, input bit au, input logic [3:0] ld);
      int t;
      bit acc, drp;
      t = au ? m_ptr : sel;
      acc = wr && (!m_rdy[t] || ld[t]);
      drp = wr && !acc;
      for (int i = 0; i < 4; i++) if (ld[i]) m_rdy[i] = 0;
      if (acc) begin
         m_q[t] = d;
         m_rdy[t] = 1;
         if (au) m_ptr = (m_ptr + 1) % 4;
      end
      m_err = drp;
      if (drp && m_cnt < 15) m_cnt++;
   endtask

   function automatic logic [15:0] model_hold();
      logic [15:0] h;
      for (int i = 0; i < 4; i++) h[i*4 +: 4] = 4'(m_q[i]);
      return h;
   endfunction

   function automatic logic [3:0] model_rdy();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = m_rdy[i];
      return r;
   endfunction

   initial begin
      //            d     sel  wr  au  lido     hold      pronto  erro desc ptr
      vecs[0] = '{4'h3, 2'd3, 1, 0, 4'b0000, 16'h3000, 4'b1000, 0, 4'd0, 2'd0};
      vecs[1] = '{4'h2, 2'd2, 1, 0, 4'b0000, 16'h3200, 4'b1100, 0, 4'd0, 2'd0};
      vecs[2] = '{4'h1, 2'd1, 1, 0, 4'b0000, 16'h3210, 4'b1110, 0, 4'd0, 2'd0};
      vecs[3] = '{4'h0, 2'd0, 1, 0, 4'b0000, 16'h3210, 4'b1111, 0, 4'd0, 2'd0};
      vecs[4] = '{4'h5, 2'd1, 1, 0, 4'b0010, 16'h3250, 4'b1111, 0, 4'd0, 2'd0};
      vecs[5] = '{4'h0, 2'd0, 0, 0, 4'b0100, 16'h3250, 4'b1011, 0, 4'd0, 2'd0};
      vecs[6] = '{4'h9, 2'd0, 1, 0, 4'b0000, 16'h3250, 4'b1011, 1, 4'd1, 2'd0};
      vecs[7] = '{4'h0, 2'd0, 0, 0, 4'b0000, 16'h3250, 4'b1011, 0, 4'd1, 2'd0};
      vecs[8] = '{4'h7, 2'd2, 1, 0, 4'b0001, 16'h3750, 4'b1110, 0, 4'd1, 2'd0};
      vecs[9] = '{4'h0, 2'd0, 0, 0, 4'b1001, 16'h3750, 4'b0110, 0, 4'd1, 2'd0};

      do_reset();
      check_outs("reset", 16'h0000, 4'b0000, 0, 4'd0, 2'd0);

      for (int i = 0; i < 10; i++) begin
         apply(vecs[i].d, vecs[i].sel, vecs[i].wr, vecs[i].au, vecs[i].ld);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_hold, vecs[i].exp_pronto,
                    vecs[i].exp_erro, vecs[i].exp_desc, vecs[i].exp_ptr);
      end

      // Auto mode from reset: A..D fill channels, E and F are dropped.
      do_reset();
      apply(4'hA, 2'd3, 1, 1, 4'b0000);
      check_outs("auto1", 16'h000A, 4'b0001, 0, 4'd0, 2'd1);
      apply(4'hB, 2'd3, 1, 1, 4'b0000);
      apply(4'hC, 2'd3, 1, 1, 4'b0000);
      apply(4'hD, 2'd3, 1, 1, 4'b0000);
      check_outs("auto4", 16'hDCBA, 4'b1111, 0, 4'd0, 2'd0);
      apply(4'hE, 2'd3, 1, 1, 4'b0000);
      check_outs("auto5", 16'hDCBA, 4'b1111, 1, 4'd1, 2'd0);
      apply(4'hF, 2'd3, 1, 1, 4'b0000);
      check_outs("auto6", 16'hDCBA, 4'b1111, 1, 4'd2, 2'd0);

      // Twenty more drops into full channel 0: counter saturates at 15.
      for (int i = 0; i < 20; i++) begin
         apply(4'h1, 2'd0, 1, 0, 4'b0000);
         check($sformatf("sat%0d.erro", i), erro, 1'b1);
         check($sformatf("sat%0d.descartes", i), descartes, (i + 3 > 15) ? 4'd15 : 4'(i + 3));
      end
      apply(4'h1, 2'd0, 0, 0, 4'b0000);
      check_outs("sat_idle", 16'hDCBA, 4'b1111, 0, 4'd15, 2'd0);

      // Build pronto=1011, descartes=7, then reset asynchronously between edges.
      do_reset();
      apply(4'h4, 2'd0, 1, 0, 4'b0000);
      apply(4'h5, 2'd1, 1, 0, 4'b0000);
      apply(4'h6, 2'd3, 1, 0, 4'b0000);
      for (int i = 0; i < 7; i++) apply(4'h8, 2'd1, 1, 0, 4'b0000);
      check_outs("pre_rst", 16'h6054, 4'b1011, 1, 4'd7, 2'd0);
      #2 reset = 1'b1;
      #1;
      check({Q3, Q2, Q1, Q0}, 16'h0, 16'h0);
      check_outs("async_rst", 16'h0000, 4'b0000, 0, 4'd0, 2'd0);
      #1 reset = 1'b0;
      apply(4'h6, 2'd2, 1, 1, 4'b0000);
      check_outs("post_rst", 16'h0006, 4'b0001, 0, 4'd0, 2'd1);

      // Random traffic against the behavioural model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [3:0] d, ld;
         logic [1:0] sel;
         logic wr, au;
         d   = 4'($urandom_range(0, 15));
         sel = 2'($urandom_range(0, 3));
         wr  = ($urandom_range(0, 3) != 0);
         au  = ($urandom_range(0, 1) != 0);
         ld  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         apply(d, sel, wr, au, ld);
         model_step(d, sel, wr, au, ld);
         check_outs($sformatf("rnd%0d", n), model_hold(), model_rdy(), m_err, 4'(m_cnt), 2'(m_ptr));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
